adc_sequencer: RTL and testbench

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_seq_pkg.sv | 26 ++
 rtl/adc_seq_next_ch.sv | 27 ++
 rtl/adc_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC scan sequencer: the FSM state encoding,
// the settle-counter type and a helper that sizes channel indices.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_OUTPUT
    } seq_state_t;

    // Largest channel count the sequencer is meant to be built with.
    localparam int MAX_NUM_CH = 16;

    // Settle counter is wide enough for any settle time up to 255 cycles.
    localparam int SETTLE_CNT_W = 8;
    typedef logic [SETTLE_CNT_W-1:0] settle_cnt_t;

    // Bits needed to index num_ch channels (never less than one bit).
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/adc_seq_next_ch.sv
// Combinational next-set-bit finder over the channel mask.
// With first_i set it returns the lowest set bit; otherwise the lowest
// set bit strictly above cur_i. found_o is low when no such bit exists.
module adc_seq_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_i,
    input  logic              first_i,
    output logic [CH_W-1:0]   next_o,
    output logic              found_o
);

    // Scan from the top down so the lowest qualifying bit is the last one written.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// ADC scan sequencer: walks the enabled channels in ascending order,
// settles the analog mux, pulses the ADC start, waits for the ready
// level to drop and rise again, then offers the result on a
// valid/ready stream. Continuous mode relatches the mask after each scan.
// Optional conversion watchdog is built when ADC_SEQ_TIMEOUT_EN is defined.
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int RESOLUTION     = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      cont_i,
    input  logic [NUM_CH-1:0]         ch_mask_i,
    output logic [$clog2(NUM_CH)-1:0] mux_sel_o,
    output logic                      adc_start_o,
    input  logic                      adc_rdy_i,
    input  logic [RESOLUTION-1:0]     adc_result_i,
    output logic                      data_valid_o,
    input  logic                      data_ready_i,
    output logic [RESOLUTION-1:0]     data_o,
    output logic [$clog2(NUM_CH)-1:0] data_ch_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int          CH_W        = ch_idx_width(NUM_CH);
    localparam settle_cnt_t SETTLE_LAST = settle_cnt_t'(SETTLE_CYCLES);

    // Reject parameter values the sequencer was not designed for.
    if (NUM_CH < 2 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
        $error("adc_sequencer: NUM_CH must be in 2..16");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("adc_sequencer: SETTLE_CYCLES must be in 0..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("adc_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t            state_q, state_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    settle_cnt_t           settle_q, settle_d;
    logic [RESOLUTION-1:0] data_q, data_d;
    logic [CH_W-1:0]       data_ch_q, data_ch_d;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    logic [CH_W-1:0]   nxt_ch, first_ch;
    logic              nxt_found, first_found;
    seq_state_t        adv_state;
    logic [CH_W-1:0]   adv_ch;
    logic [NUM_CH-1:0] adv_mask;

    // Next enabled channel above the current one within the latched mask.
    adc_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_in_scan (
        .mask_i  (mask_q),
        .cur_i   (ch_q),
        .first_i (1'b0),
        .next_o  (nxt_ch),
        .found_o (nxt_found)
    );

    // Lowest enabled channel of the live mask, used whenever the mask is latched.
    adc_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_first_live (
        .mask_i  (ch_mask_i),
        .cur_i   ('0),
        .first_i (1'b1),
        .next_o  (first_ch),
        .found_o (first_found)
    );

    // Where to go once the current channel is finished (transferred or skipped).
    always_comb begin
        adv_state = ST_IDLE;
        adv_ch    = ch_q;
        adv_mask  = mask_q;
        if (nxt_found) begin
            adv_state = ST_SETTLE;
            adv_ch    = nxt_ch;
        end else if (cont_i) begin
            adv_mask = ch_mask_i;
            if (first_found) begin
                adv_state = ST_SETTLE;
                adv_ch    = first_ch;
            end
        end
    end

    // Next-state logic for the scan FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        settle_d  = settle_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
`ifdef ADC_SEQ_TIMEOUT_EN
        wd_d      = '0;
        timeout_d = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i && first_found) begin
                    state_d  = ST_SETTLE;
                    mask_d   = ch_mask_i;
                    ch_d     = first_ch;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_START;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
`ifdef ADC_SEQ_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                if (!adc_rdy_i) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
`ifdef ADC_SEQ_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                if (adc_rdy_i) begin
                    state_d   = ST_OUTPUT;
                    data_d    = adc_result_i;
                    data_ch_d = ch_q;
                end
            end
            ST_OUTPUT: begin
                if (data_ready_i) begin
                    state_d  = adv_state;
                    ch_d     = adv_ch;
                    mask_d   = adv_mask;
                    settle_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef ADC_SEQ_TIMEOUT_EN
        if ((state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) &&
            (state_d == state_q) && (wd_q >= WD_LAST)) begin
            timeout_d = 1'b1;
            state_d   = adv_state;
            ch_d      = adv_ch;
            mask_d    = adv_mask;
            wd_d      = '0;
        end
`endif
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            ch_q      <= '0;
            settle_q  <= '0;
            data_q    <= '0;
            data_ch_q <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            settle_q  <= settle_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
`ifdef ADC_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign mux_sel_o    = ch_q;
    assign adc_start_o  = (state_q == ST_START);
    assign data_valid_o = (state_q == ST_OUTPUT);
    assign data_o       = data_q;
    assign data_ch_o    = data_ch_q;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef ADC_SEQ_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sequencer.sv
// Testbench for adc_sequencer. Drives directed and randomized scans,
// models the ADC's ready/result behaviour, and compares every streamed
// result against the channel order derived from the mask plus the values
// the ADC model produced. Timeout scenario runs when ADC_SEQ_TIMEOUT_EN is defined.
module tb_adc_sequencer;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } rec_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       cont_i;
    logic [3:0] ch_mask_i;
    logic [1:0] mux_sel_o;
    logic       adc_start_o;
    logic       adc_rdy_i;
    logic [7:0] adc_result_i;
    logic       data_valid_o;
    logic       data_ready_i;
    logic [7:0] data_o;
    logic [1:0] data_ch_o;
    logic       busy_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    rec_t       got[$];
    logic [7:0] adc_q[$];
    int         exp_ch[$];

    int conv_min   = 2;
    int conv_max   = 5;
    bit stuck_en   = 1'b0;
    int serve_left = 0;
    bit bp_en      = 1'b0;
    bit seen_valid = 1'b0;

    adc_sequencer #(
        .NUM_CH         (4),
        .RESOLUTION     (8),
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cont_i       (cont_i),
        .ch_mask_i    (ch_mask_i),
        .mux_sel_o    (mux_sel_o),
        .adc_start_o  (adc_start_o),
        .adc_rdy_i    (adc_rdy_i),
        .adc_result_i (adc_result_i),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .data_ch_o    (data_ch_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // ADC model: on a start pulse drop ready, convert for a random time,
    // then present a fresh random result and raise ready again.
    initial begin
        logic [7:0] val;
        forever begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) begin
                if (stuck_en && serve_left == 0) begin
                    adc_rdy_i = 1'b1;
                end else begin
                    if (stuck_en) serve_left--;
                    adc_rdy_i    = 1'b0;
                    adc_result_i = 8'($urandom);
                    repeat ($urandom_range(conv_min, conv_max)) @(negedge clk_i);
                    val          = 8'($urandom);
                    adc_result_i = val;
                    adc_rdy_i    = 1'b1;
                    adc_q.push_back(val);
                end
            end
        end
    end

    // Stream monitor: records every accepted result, notes any valid cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk_i);
            #1;
            if (data_valid_o === 1'b1) seen_valid = 1'b1;
            if (data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
                r.data = data_o;
                r.ch   = data_ch_o;
                got.push_back(r);
            end
        end
    end

    // Random backpressure on the result stream while enabled.
    initial begin
        forever begin
            @(negedge clk_i);
            if (bp_en) data_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic cont);
        @(negedge clk_i);
        ch_mask_i = mask;
        cont_i    = cont;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    // Reference model: one scan visits the set bits of its mask, lowest first.
    task automatic add_scan_expect(input logic [3:0] mask);
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) exp_ch.push_back(ch);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o === 1'b1 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        #2;
        checkOutput({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_scan(input string tag);
        checkOutput({tag, "_count"}, got.size(), exp_ch.size());
        checkOutput({tag, "_convs"}, adc_q.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size(); i++) begin
            if (i < got.size()) begin
                checkOutput($sformatf("%s_ch%0d", tag, i), 32'(got[i].ch), exp_ch[i]);
                if (i < adc_q.size())
                    checkOutput($sformatf("%s_data%0d", tag, i), 32'(got[i].data), 32'(adc_q[i]));
            end
        end
        got.delete();
        adc_q.delete();
        exp_ch.delete();
    endtask

    initial begin
        int         n;
        int         lo;
        int         hold_bad;
        int         hold_starts;
        logic [7:0] hold_data;
        logic [3:0] mask;

        rst_i        = 1'b1;
        start_i      = 1'b0;
        cont_i       = 1'b0;
        ch_mask_i    = 4'b0000;
        adc_rdy_i    = 1'b1;
        adc_result_i = 8'h00;
        data_ready_i = 1'b1;

        // Reset values while reset is held.
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rst_mux_sel", 32'(mux_sel_o), 32'd0);
        checkOutput("rst_adc_start", 32'(adc_start_o), 32'd0);
        checkOutput("rst_data_valid", 32'(data_valid_o), 32'd0);
        checkOutput("rst_data", 32'(data_o), 32'd0);
        checkOutput("rst_data_ch", 32'(data_ch_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single scan over channels 0, 1 and 3.
        $display("[TB] scan mask 1011");
        applyStimulus(4'b1011, 1'b0);
        wait_idle("scan1011", 200);
        add_scan_expect(4'b1011);
        check_scan("scan1011");

        // Start pulse with an empty mask must be ignored.
        applyStimulus(4'b0000, 1'b0);
        repeat (3) @(negedge clk_i);
        checkOutput("zero_mask_busy", 32'(busy_o), 32'd0);

        // Start comes three cycles after the mux moves, and is one cycle wide.
        mask = 4'b0100;
        lo = -1;
        for (int i = 0; i < 4; i++) if (mask[i] && lo < 0) lo = i;
        applyStimulus(mask, 1'b0);
        checkOutput("settle_mux_sel", 32'(mux_sel_o), 32'(lo));
        n = 0;
        while (adc_start_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("settle_start_delay", n, 32'd3);
        @(negedge clk_i);
        checkOutput("settle_start_width", 32'(adc_start_o), 32'd0);
        wait_idle("settle", 100);
        add_scan_expect(mask);
        check_scan("settle");

        // Backpressure: result must hold and no new conversion may start.
        data_ready_i = 1'b0;
        applyStimulus(4'b0110, 1'b0);
        n = 0;
        while (data_valid_o !== 1'b1 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("hold_valid", 32'(data_valid_o), 32'd1);
        checkOutput("hold_conv_count", adc_q.size(), 32'd1);
        hold_data = (adc_q.size() > 0) ? adc_q[0] : 8'h00;
        checkOutput("hold_first_ch", 32'(data_ch_o), 32'd1);
        hold_bad    = 0;
        hold_starts = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (data_o !== hold_data || data_ch_o !== 2'd1 || data_valid_o !== 1'b1) hold_bad++;
            if (adc_start_o === 1'b1) hold_starts++;
        end
        checkOutput("hold_stable", hold_bad, 32'd0);
        checkOutput("hold_no_start", hold_starts, 32'd0);
        data_ready_i = 1'b1;
        wait_idle("hold", 100);
        add_scan_expect(4'b0110);
        check_scan("hold");

        // Continuous mode: mask change takes effect only at the next scan.
        applyStimulus(4'b0001, 1'b1);
        ch_mask_i = 4'b0100;
        n = 0;
        while (got.size() < 1 && n < 60) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        repeat (2) @(negedge clk_i);
        cont_i = 1'b0;
        wait_idle("cont", 100);
        add_scan_expect(4'b0001);
        add_scan_expect(4'b0100);
        check_scan("cont");

        // Reset while the DUT is waiting for ready to rise.
        conv_min = 8;
        conv_max = 8;
        seen_valid = 1'b0;
        applyStimulus(4'b0100, 1'b0);
        n = 0;
        while (adc_rdy_i !== 1'b0 && n < 20) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        repeat (2) @(negedge clk_i);
        checkOutput("midrst_busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_mux_sel", 32'(mux_sel_o), 32'd0);
        checkOutput("midrst_data_valid", 32'(data_valid_o), 32'd0);
        checkOutput("midrst_data", 32'(data_o), 32'd0);
        checkOutput("midrst_data_ch", 32'(data_ch_o), 32'd0);
        checkOutput("midrst_adc_start", 32'(adc_start_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen_valid = 1'b0;
        n = 0;
        while (adc_rdy_i !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        repeat (6) @(negedge clk_i);
        #2;
        checkOutput("midrst_no_valid", 32'(seen_valid), 32'd0);
        checkOutput("midrst_idle", 32'(busy_o), 32'd0);
        got.delete();
        adc_q.delete();
        conv_min = 2;
        conv_max = 5;

        // Randomized scans with backpressure and mid-scan start/mask noise.
        bp_en = 1'b1;
        for (int it = 0; it < 8; it++) begin
            mask = 4'($urandom_range(0, 15));
            applyStimulus(mask, 1'b0);
            if (mask == 4'b0000) begin
                repeat (3) @(negedge clk_i);
                checkOutput($sformatf("rnd%0d_zero_busy", it), 32'(busy_o), 32'd0);
                checkOutput($sformatf("rnd%0d_zero_out", it), got.size(), 32'd0);
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk_i);
                ch_mask_i = 4'($urandom);
                start_i   = 1'b1;
                @(negedge clk_i);
                start_i   = 1'b0;
                wait_idle($sformatf("rnd%0d", it), 500);
                add_scan_expect(mask);
                check_scan($sformatf("rnd%0d", it));
            end
        end
        bp_en = 1'b0;
        @(negedge clk_i);
        data_ready_i = 1'b1;

`ifdef ADC_SEQ_TIMEOUT_EN
        // Watchdog: ADC never drops ready for channel 1, which gets skipped.
        stuck_en   = 1'b1;
        serve_left = 1;
        applyStimulus(4'b0011, 1'b0);
        wait_idle("timeout", 300);
        checkOutput("timeout_flag", 32'(timeout_o), 32'd1);
        add_scan_expect(4'b0001);
        check_scan("timeout");
        stuck_en = 1'b0;
`else
        checkOutput("timeout_tied_low", 32'(timeout_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
